// File: rtl/zcd_pkg.sv
// Shared definitions for the zero-crossing window packetizer.
// Holds the FSM state enum, the trailer tag bit and the default parameter values.
// Optional feature macro: ZCD_PKT_TRAILER_EN adds the TRAILER state.
package zcd_pkg;

   localparam int unsigned DefDataWidth = 46;
   localparam int unsigned DefRegWidth  = 32;
   localparam int unsigned DefFifoDepth = 16;

   // MSB of the trailer word, marking it apart from sample data.
   localparam logic TrailerTag = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StCapture,
      StClose,
`ifdef ZCD_PKT_TRAILER_EN
      StTrailer,
`endif
      StWaitLow
   } state_e;

endpackage

// File: rtl/zcd_pkt_fifo.sv
// Synchronous first-word-fall-through FIFO for the packetizer output stream.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request and word (ignored when full unless popping)
//   pop               read request (ignored when empty)
//   pop_data          head word, forced to zero while empty
//   full, empty       occupancy flags
module zcd_pkt_fifo #(
   parameter int unsigned Width = 47,
   parameter int unsigned Depth = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic [Width-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned Aw = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Aw:0]      wr_ptr_q, rd_ptr_q;
   logic             do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign pop_data = empty ? '0 : mem_q[rd_ptr_q[Aw-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + {{Aw{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr_q <= rd_ptr_q + {{Aw{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= push_data;
   end

endmodule

// File: rtl/zcd_window_packetizer.sv
// Packs samples captured while the zero-crossing detector holds "save" high into
// AXI-Stream packets. One sample is held back so the final word can carry tlast.
// Optional feature macro: ZCD_PKT_TRAILER_EN appends a {1, 0..., sample count} trailer
// word carrying tlast after each non-empty packet.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_data, in_data_valid         tagged sample word and qualifier
//   save                           capture window gate
//   max_packet_samples             per-packet sample limit, 0 = unlimited
//   m_axis_tdata/tvalid/tready/tlast  output stream
//   overflow                       sticky, a window sample was dropped
//   packet_count                   packets closed since reset (wraps)
//   busy                           FSM not idle
module zcd_window_packetizer
   import zcd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned REG_WIDTH  = DefRegWidth,
   parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_data_valid,
   input  logic                  save,
   input  logic [REG_WIDTH-1:0]  max_packet_samples,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  overflow,
   output logic [REG_WIDTH-1:0]  packet_count,
   output logic                  busy
);

   state_e                state_q, state_d;
   logic                  save_q;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_vld_q, hold_vld_d;
   logic [REG_WIDTH-1:0]  cnt_q, cnt_d, cnt_base;
   logic                  ovf_q, ovf_d;
   logic [REG_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;

   logic                  push, pop, push_ok, full, empty;
   logic [DATA_WIDTH:0]   push_word, pop_word;
   logic                  load, start, drop;

   assign pop     = m_axis_tvalid && m_axis_tready;
   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign push_ok = !full || pop;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      pkt_cnt_d  = pkt_cnt_q;
      push       = 1'b0;
      push_word  = {1'b0, hold_q};
      load       = 1'b0;
      start      = 1'b0;
      drop       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (save && !save_q) begin
               start   = 1'b1;
               load    = in_data_valid;
               state_d = StCapture;
            end
         end
         StCapture: begin
            if (!save) state_d = StClose;
            else       load    = in_data_valid;
         end
         StClose: begin
            if (!hold_vld_q) begin
               state_d = StWaitLow;
            end else begin
               push = 1'b1;
`ifdef ZCD_PKT_TRAILER_EN
               push_word = {1'b0, hold_q};
               if (push_ok) begin
                  hold_vld_d = 1'b0;
                  state_d    = StTrailer;
               end
`else
               push_word = {1'b1, hold_q};
               if (push_ok) begin
                  hold_vld_d = 1'b0;
                  pkt_cnt_d  = pkt_cnt_q + REG_WIDTH'(1);
                  state_d    = StWaitLow;
               end
`endif
            end
         end
`ifdef ZCD_PKT_TRAILER_EN
         StTrailer: begin
            push      = 1'b1;
            push_word = {1'b1, TrailerTag, {(DATA_WIDTH-1-REG_WIDTH){1'b0}}, cnt_q};
            if (push_ok) begin
               pkt_cnt_d = pkt_cnt_q + REG_WIDTH'(1);
               state_d   = StWaitLow;
            end
         end
`endif
         StWaitLow: begin
            // Holds off re-arming until the current window has ended.
            if (!save) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      cnt_base = start ? '0 : cnt_q;
      if (start) cnt_d = '0;

      if (load) begin
         hold_d     = in_data;
         hold_vld_d = 1'b1;
         if (hold_vld_q) begin
            push      = 1'b1;
            push_word = {1'b0, hold_q};
            if (!push_ok) begin
               drop  = 1'b1;
               ovf_d = 1'b1;
            end
         end
         // A dropped word cancels the newly loaded one, so the count tracks retained words.
         if (!drop && cnt_base != '1) cnt_d = cnt_base + REG_WIDTH'(1);
         else                         cnt_d = cnt_base;
         if (max_packet_samples != '0 && cnt_d == max_packet_samples) state_d = StClose;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         save_q     <= 1'b0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         pkt_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         save_q     <= save;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   zcd_pkt_fifo #(
      .Width (DATA_WIDTH + 1),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_word),
      .pop       (pop),
      .pop_data  (pop_word),
      .full      (full),
      .empty     (empty)
   );

   assign m_axis_tvalid = !empty;
   assign m_axis_tlast  = pop_word[DATA_WIDTH];
   assign m_axis_tdata  = pop_word[DATA_WIDTH-1:0];
   assign overflow      = ovf_q;
   assign packet_count  = pkt_cnt_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_zcd_window_packetizer.sv
module tb_zcd_window_packetizer;

   localparam int unsigned DW = 46;
   localparam int unsigned RW = 32;
   localparam int unsigned FD = 16;
`ifdef ZCD_PKT_TRAILER_EN
   localparam bit TrailerEn = 1'b1;
`else
   localparam bit TrailerEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_data;
   logic          in_data_valid;
   logic          save;
   logic [RW-1:0] max_packet_samples;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          overflow;
   logic [RW-1:0] packet_count;
   logic          busy;

   zcd_window_packetizer #(
      .DATA_WIDTH (DW),
      .REG_WIDTH  (RW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .in_data            (in_data),
      .in_data_valid      (in_data_valid),
      .save               (save),
      .max_packet_samples (max_packet_samples),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tready      (m_axis_tready),
      .m_axis_tlast       (m_axis_tlast),
      .overflow           (overflow),
      .packet_count       (packet_count),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_fail = 0;
   int            rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
   int            stall_viol = 0;
   int unsigned   exp_pc = 0;
   logic          prev_stall = 1'b0;
   logic [DW:0]   prev_word;
   logic [DW:0]   out_q [$];
   logic [DW:0]   exp_q [$];
   logic [DW-1:0] cap_q [$];

   // Stream monitor: records accepted beats and flags any change while stalled.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_word))
            stall_viol++;
         if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_word  = {m_axis_tlast, m_axis_tdata};
      end
   end

   function automatic logic [DW-1:0] rnd_word();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = 1'($urandom_range(0, 1));
         default: m_axis_tready = 1'b0;
      endcase
   endtask

   // Drives one save window of len cycles; every valid cycle inside it is a candidate sample.
   task automatic drive_window(input int len, input int pct);
      save = 1'b0; in_data_valid = 1'($urandom_range(0, 1)); in_data = rnd_word();
      tick();
      cap_q.delete();
      for (int i = 0; i < len; i++) begin
         save = 1'b1;
         in_data_valid = ($urandom_range(0, 99) < pct);
         in_data = rnd_word();
         if (in_data_valid) cap_q.push_back(in_data);
         tick();
      end
      save = 1'b0; in_data_valid = 1'($urandom_range(0, 1)); in_data = rnd_word();
      tick();
      in_data_valid = 1'b0;
   endtask

   // Reference: packet = first min(n, limit) samples, tlast on the end, optional trailer.
   task automatic build_expected(input int unsigned maxs);
      int unsigned   n;
      logic [DW-1:0] tw;
      n = cap_q.size();
      if (maxs != 0 && n > maxs) n = maxs;
      exp_q.delete();
      for (int unsigned i = 0; i < n; i++)
         exp_q.push_back({(i == n - 1) && !TrailerEn, cap_q[i]});
      if (TrailerEn && n > 0) begin
         tw = '0; tw[DW-1] = 1'b1; tw[RW-1:0] = n;
         exp_q.push_back({1'b1, tw});
      end
      if (n > 0) exp_pc++;
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!busy && !m_axis_tvalid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; save = 1'b1; in_data_valid = 1'b1; in_data = rnd_word();
      max_packet_samples = '0; rdy_mode = 0;
      tick(); tick(); tick();
      n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
      n_cmp++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
      n_cmp++; if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
      n_cmp++; if (packet_count !== '0) begin n_fail++; $display("FAIL reset_pcount got %0d want 0", packet_count); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      save = 1'b0; in_data_valid = 1'b0;
      rst = 1'b0;
      tick();
      exp_pc = 0;
      out_q.delete();
   endtask

   task automatic test_basic();
      bit ok;
      max_packet_samples = '0; rdy_mode = 0; out_q.delete();
      drive_window(5, 100);
      build_expected(0);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_drain got timeout want idle"); end
      n_cmp++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_len got %0d want %0d", out_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         n_cmp++; if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word%0d got %h want %h", i, out_q[i], exp_q[i]); end
      end
      n_cmp++; if (packet_count !== RW'(exp_pc)) begin n_fail++; $display("FAIL basic_pcount got %0d want %0d", packet_count, exp_pc); end
   endtask

   task automatic test_limit();
      bit ok;
      max_packet_samples = 3; rdy_mode = 0; out_q.delete();
      drive_window(10, 100);
      build_expected(3);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL limit_drain got timeout want idle"); end
      n_cmp++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL limit_len got %0d want %0d", out_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         n_cmp++; if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL limit_word%0d got %h want %h", i, out_q[i], exp_q[i]); end
      end
      n_cmp++; if (packet_count !== RW'(exp_pc)) begin n_fail++; $display("FAIL limit_pcount got %0d want %0d", packet_count, exp_pc); end
      max_packet_samples = '0;
   endtask

   task automatic test_overflow();
      bit            ok;
      logic [DW-1:0] tw;
      max_packet_samples = '0; rdy_mode = 2; out_q.delete();
      drive_window(20, 100);
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_close_stall got busy=%b want 1", busy); end
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, cap_q[i]});
      exp_q.push_back({!TrailerEn, cap_q[19]});
      if (TrailerEn) begin
         tw = '0; tw[DW-1] = 1'b1; tw[RW-1:0] = 17;
         exp_q.push_back({1'b1, tw});
      end
      exp_pc++;
      rdy_mode = 0;
      tick();
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL ovf_drain got timeout want idle"); end
      n_cmp++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_len got %0d want %0d", out_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         n_cmp++; if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_word%0d got %h want %h", i, out_q[i], exp_q[i]); end
      end
      n_cmp++; if (packet_count !== RW'(exp_pc)) begin n_fail++; $display("FAIL ovf_pcount got %0d want %0d", packet_count, exp_pc); end
      rst = 1'b1; tick(); rst = 1'b0; tick();
      exp_pc = 0;
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got %b want 0", overflow); end
   endtask

   task automatic test_empty_window();
      bit ok;
      max_packet_samples = '0; rdy_mode = 0; out_q.delete();
      drive_window(3, 0);
      build_expected(0);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL empty_drain got timeout want idle"); end
      n_cmp++; if (out_q.size() != 0) begin n_fail++; $display("FAIL empty_beats got %0d want 0", out_q.size()); end
      n_cmp++; if (packet_count !== RW'(exp_pc)) begin n_fail++; $display("FAIL empty_pcount got %0d want %0d", packet_count, exp_pc); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      max_packet_samples = '0; rdy_mode = 0;
      save = 1'b0; in_data_valid = 1'b0; tick();
      for (int i = 0; i < 2; i++) begin
         save = 1'b1; in_data_valid = 1'b1; in_data = rnd_word(); tick();
      end
      rst = 1'b1; tick();
      rst = 1'b0; save = 1'b0; in_data_valid = 1'b0;
      n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid got %b want 0", m_axis_tvalid); end
      n_cmp++; if (packet_count !== '0) begin n_fail++; $display("FAIL rstmid_pcount got %0d want 0", packet_count); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
      exp_pc = 0;
      out_q.delete();
      drive_window(4, 100);
      build_expected(0);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_drain got timeout want idle"); end
      n_cmp++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_len got %0d want %0d", out_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         n_cmp++; if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_word%0d got %h want %h", i, out_q[i], exp_q[i]); end
      end
      n_cmp++; if (packet_count !== RW'(exp_pc)) begin n_fail++; $display("FAIL rstmid_pcount2 got %0d want %0d", packet_count, exp_pc); end
   endtask

   task automatic test_random();
      bit          ok;
      int unsigned maxs;
      for (int w = 0; w < 40; w++) begin
         maxs = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
         max_packet_samples = maxs;
         rdy_mode = $urandom_range(0, 1);
         out_q.delete();
         // At most 15 samples per window, so the FIFO cannot overflow.
         drive_window($urandom_range(1, 15), $urandom_range(0, 100));
         build_expected(maxs);
         wait_drain(ok);
         n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand%0d_drain got timeout want idle", w); end
         n_cmp++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len got %0d want %0d", w, out_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            n_cmp++; if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word%0d got %h want %h", w, i, out_q[i], exp_q[i]); end
         end
         n_cmp++; if (packet_count !== RW'(exp_pc)) begin n_fail++; $display("FAIL rand%0d_pcount got %0d want %0d", w, packet_count, exp_pc); end
      end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_overflow got %b want 0", overflow); end
      max_packet_samples = '0;
      rdy_mode = 0;
   endtask

`ifdef ZCD_PKT_TRAILER_EN
   task automatic test_trailer();
      bit          ok;
      logic [DW:0] want;
      want = {1'b1, 46'h2000_0000_0004};
      max_packet_samples = '0; rdy_mode = 0; out_q.delete();
      drive_window(4, 100);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL trailer_drain got timeout want idle"); end
      n_cmp++; if (out_q.size() != 5) begin n_fail++; $display("FAIL trailer_len got %0d want 5", out_q.size()); end
      if (out_q.size() == 5) begin
         n_cmp++; if (out_q[4] !== want) begin n_fail++; $display("FAIL trailer_word got %h want %h", out_q[4], want); end
         n_cmp++; if (out_q[3] !== {1'b0, cap_q[3]}) begin n_fail++; $display("FAIL trailer_lastdata got %h want %h", out_q[3], {1'b0, cap_q[3]}); end
      end
      exp_pc++;
   endtask
`endif

   task automatic test_hold_stable();
      n_cmp++; if (stall_viol != 0) begin n_fail++; $display("FAIL hold_stable got %0d changes want 0", stall_viol); end
   endtask

   initial begin
      rst = 1'b1; save = 1'b0; in_data_valid = 1'b0; in_data = '0;
      max_packet_samples = '0; m_axis_tready = 1'b1;
      test_reset();
      test_basic();
      test_limit();
      test_overflow();
      test_empty_window();
      test_reset_mid();
`ifdef ZCD_PKT_TRAILER_EN
      test_trailer();
`endif
      test_random();
      test_hold_stable();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/zcd_window_packetizer.md
ZCD_WINDOW_PACKETIZER -- requirements
Module: zcd_window_packetizer

Interface
REQ-001 DATA_WIDTH, 46, sample word width; MSB is the ZCD tag bit and passes through unchanged.
REQ-002 REG_WIDTH, 32, width of counters and limits.
REQ-003 FIFO_DEPTH, 16, output FIFO depth in words; power of 2, >=4.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_data  in  DATA_WIDTH  tagged sample word from the zero-crossing detector.
REQ-007 in_data_valid  in  1  sample qualifier, one word per high cycle.
REQ-008 save  in  1  capture window gate from the zero-crossing detector.
REQ-009 max_packet_samples  in  REG_WIDTH  per-packet sample limit; 0 = unlimited.
REQ-010 m_axis_tdata  out  DATA_WIDTH  AXI-Stream data.
REQ-011 m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1  AXI-Stream handshake and end of packet.
REQ-012 overflow  out  1  sticky: a window sample was dropped.
REQ-013 packet_count  out  REG_WIDTH  number of packets closed since reset.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, CAPTURE, CLOSE, TRAILER, WAIT_LOW.
REQ-016 IDLE -> CAPTURE on a rising edge of save (save=1, registered save=0); a sample valid in that same cycle is captured.
REQ-017 CAPTURE: each in_data_valid with save=1 loads a one-word hold register; the previous held word (if any) is pushed to the FIFO with last=0; sample_cnt increments.
REQ-018 CAPTURE ends when save=0 (-> CLOSE) or sample_cnt == max_packet_samples != 0 after the load (-> CLOSE, input ignored thereafter).
REQ-019 CLOSE pushes the held word with last=1 (trailer disabled) or last=0 (trailer enabled, -> TRAILER); it stalls while the FIFO is full and never drops the word.
REQ-020 A window with zero captured samples emits nothing, leaves packet_count unchanged, and goes CLOSE -> WAIT_LOW.
REQ-021 WAIT_LOW -> IDLE once save=0; this prevents re-triggering inside a window truncated by the limit.
REQ-022 packet_count increments exactly once per packet, in the cycle the last=1 word is pushed; it wraps modulo 2^REG_WIDTH.
REQ-023 In CAPTURE, a push attempted while the FIFO is full drops the word, sets overflow, and leaves sample_cnt counting accepted words only.
REQ-024 FIFO is first-word-fall-through: m_axis_tvalid rises the cycle after the first push; tdata/tlast are held stable while tvalid=1 and tready=0.
REQ-025 A simultaneous FIFO push and pop when full is legal and does not count as overflow.
REQ-026 sample_cnt is REG_WIDTH wide and saturates at all-ones.

Reset
REQ-027 While rst=1: FSM = IDLE, FIFO empty, hold register invalid, sample_cnt=0, registered save=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow=0, packet_count=0, busy=0.
REQ-028 Reset asserted mid-packet discards the partial packet with no tlast emitted; rst has priority over all other inputs.

Configuration
REQ-029 Macro ZCD_PKT_TRAILER_EN defined: after the last sample, TRAILER pushes one word {1'b1, zero pad, sample_cnt[REG_WIDTH-1:0]} with last=1, stalls while the FIFO is full, then -> WAIT_LOW.
REQ-030 Macro ZCD_PKT_TRAILER_EN undefined: the TRAILER state and its logic are absent, and CLOSE -> WAIT_LOW directly.

Structure
REQ-031 The shared package zcd_pkg holds the FSM state enum, the trailer tag constant, and the default parameter values.
REQ-032 Sub-module zcd_pkt_fifo: synchronous FWFT FIFO of width DATA_WIDTH+1 (data + last) with full/empty outputs; the FSM stays in the top level.

Verification
REQ-033 save high 5 cycles, in_data_valid high continuously, tready=1 -> 5 words out (or 4 if the edge cycle is excluded by stimulus), tlast on the final word, packet_count=1.
REQ-034 max_packet_samples=3, save high 10 cycles -> exactly 3 words with tlast on the 3rd; no second packet until save falls and rises again.
REQ-035 tready=0 during a 20-sample window with FIFO_DEPTH=16 -> overflow=1, 17 words retained (16 in the FIFO + 1 held), tlast intact on the last retained word.
REQ-036 save pulse with in_data_valid=0 -> no output beats, packet_count unchanged, FSM returns to IDLE.
REQ-037 With ZCD_PKT_TRAILER_EN, a 4-sample window -> 4 data words plus trailer 0x2000_0000_0004 (DATA_WIDTH=46) carrying tlast.
REQ-038 rst pulsed mid-window after 2 samples -> tvalid=0 the next cycle, counters 0, and the next window produces a clean packet.
